// File: rtl/reg_display_scan.sv
// reg_display_scan: shows one of CHANNELS registers on a row of active-low
// 7-segment digits. The channel is chosen manually (Sel) or stepped
// automatically every DWELL cycles; Freeze pauses both the selection and
// the displayed value. Indices at or above CHANNELS blank the display.
module reg_display_scan #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 5,
    parameter int DWELL    = 50000000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [CHANNELS*WIDTH-1:0]    i_regs,
    input  logic [3:0]                   i_sel,
    input  logic                         i_auto,
    input  logic                         i_freeze,
    output logic [(WIDTH/4)*7-1:0]       o_hex,
    output logic [3:0]                   o_chan,
    output logic                         o_blank
);

    localparam int              DIGITS   = WIDTH / 4;
    localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [3:0]      CH_LAST  = 4'(CHANNELS - 1);
    // Five bits so that CHANNELS=16 compares correctly against a 4-bit index.
    localparam logic [4:0]      CH_COUNT = 5'(CHANNELS);

    logic [3:0]       r_ch;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dq;
    logic [3:0]       r_chan;
    logic             r_blank;

    logic [3:0]       w_ch_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_ch_oor;
    logic [WIDTH-1:0] w_sel_data;

    assign w_ch_oor = ({1'b0, r_ch} >= CH_COUNT);

    // Register mux: data of channel ch, or zero when ch is out of range.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        w_sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_ch == 4'(k)) begin
                w_sel_data = i_regs[k*WIDTH +: WIDTH];
            end
        end
    end

    // Selection next-state: manual load, auto dwell/advance, or hold on freeze.
    always_comb begin
        w_ch_next  = r_ch;
        w_cnt_next = r_cnt;
        if (!i_freeze) begin
            if (!i_auto) begin
                // Keeping cnt at 0 in manual mode makes the first auto dwell
                // last exactly DWELL cycles.
                w_ch_next  = i_sel;
                w_cnt_next = '0;
            end else if (w_ch_oor) begin
                w_ch_next  = '0;
                w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_cnt_next = '0;
                w_ch_next  = (r_ch == CH_LAST) ? 4'd0 : r_ch + 4'd1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    // State and output registers; reset overrides freeze and mode.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values (Chan below gets the old ch).
        if (i_rst) begin
            r_ch    <= '0;
            r_cnt   <= '0;
            r_dq    <= '0;
            r_chan  <= '0;
            r_blank <= 1'b1;
        end else begin
            r_ch  <= w_ch_next;
            r_cnt <= w_cnt_next;
            if (!i_freeze) begin
                r_dq    <= w_sel_data;
                r_chan  <= r_ch;
                r_blank <= w_ch_oor;
            end
        end
    end

    // Active-low hex glyph for one nibble (bit 6 = g ... bit 0 = a).
    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0:    f_seg = 7'b1000000;
            4'h1:    f_seg = 7'b1111001;
            4'h2:    f_seg = 7'b0100100;
            4'h3:    f_seg = 7'b0110000;
            4'h4:    f_seg = 7'b0011001;
            4'h5:    f_seg = 7'b0010010;
            4'h6:    f_seg = 7'b0000010;
            4'h7:    f_seg = 7'b1111000;
            4'h8:    f_seg = 7'b0000000;
            4'h9:    f_seg = 7'b0010000;
            4'hA:    f_seg = 7'b0001000;
            4'hB:    f_seg = 7'b0000011;
            4'hC:    f_seg = 7'b1000110;
            4'hD:    f_seg = 7'b0100001;
            4'hE:    f_seg = 7'b0000110;
            default: f_seg = 7'b0001110;
        endcase
    endfunction

    // Segment decode of the held data; blanking forces all segments off.
    always_comb begin
        o_hex = '1;
        for (int d = 0; d < DIGITS; d++) begin
            o_hex[d*7 +: 7] = r_blank ? 7'b1111111 : f_seg(r_dq[d*4 +: 4]);
        end
    end

    assign o_chan  = r_chan;
    assign o_blank = r_blank;

endmodule

// File: doc/reg_display_scan.md
REG_DISPLAY_SCAN -- requirements
Module: reg_display_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning register width in bits (multiple of 4, range 4..32).
REQ-002 The block SHALL have parameter CHANNELS, default 5, meaning number of selectable registers (range 2..16).
REQ-003 The block SHALL have parameter DWELL, default 50000000, meaning clock cycles per channel in auto-scan mode (>=1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 Clock  input  1  system clock; all state changes on its rising edge.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 Regs  input  CHANNELS*WIDTH  flattened register bus; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 Sel  input  4  manual channel select.
REQ-009 Auto  input  1  1 = auto-scan mode, 0 = manual mode.
REQ-010 Freeze  input  1  1 = hold displayed value and pause selection state.
REQ-011 Hex  output  (WIDTH/4)*7  active-low 7-segment patterns; digit 0 (least-significant nibble) at bits [6:0]; bit 6 = g ... bit 0 = a.
REQ-012 Chan  output  4  index of the channel currently shown on Hex.
REQ-013 Blank  output  1  high when Hex is blanked (all segments off).

Function
REQ-014 Internal state SHALL be: channel pointer ch (4 b), dwell counter cnt (wide enough for DWELL-1), display data register dq (WIDTH b), and output registers for Chan and Blank.
REQ-015 Manual mode (Auto=0, Freeze=0): ch SHALL load Sel every cycle; cnt SHALL be held at 0.
REQ-016 Auto mode (Auto=1, Freeze=0): cnt SHALL increment each cycle; when cnt==DWELL-1, cnt SHALL wrap to 0 and ch SHALL advance by 1, wrapping from CHANNELS-1 to 0.
REQ-017 In auto mode, if ch >= CHANNELS (left over from manual mode), ch SHALL load 0 on the next cycle and cnt SHALL restart at 0.
REQ-018 On the first cycle of Auto=1 after Auto=0, cnt SHALL start at 0, so the first dwell lasts exactly DWELL cycles.
REQ-019 DWELL=1 SHALL advance ch every cycle.
REQ-020 When Freeze=0, each cycle dq SHALL load Regs channel ch, Chan SHALL load ch, and Blank SHALL load (ch >= CHANNELS).
REQ-021 When ch >= CHANNELS, dq SHALL load 0; Hex SHALL then be all ones; Chan SHALL still show ch.
REQ-022 Latency: a Sel change sampled at edge n SHALL appear on Chan/Hex after edge n+1 (2 cycles); Chan and Hex SHALL always describe the same channel.
REQ-023 When Freeze=1, ch, cnt, dq, Chan and Blank SHALL all hold; Sel and Regs changes SHALL be ignored.
REQ-024 On release of Freeze, operation SHALL resume from the held ch and cnt values with no skipped or repeated dwell cycle.
REQ-025 Hex SHALL be a combinational decode of dq and Blank: Blank=1 forces every digit to 7'b1111111; otherwise each nibble decodes to standard hex glyphs (0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110).
REQ-026 Reset SHALL take priority over Freeze and Auto.

Reset
REQ-027 On Reset=1 at a rising edge: ch=0, cnt=0, dq=0, Chan=0, Blank=1, so Hex = all ones from the next cycle.
REQ-028 Reset asserted mid-dwell or during Freeze SHALL discard all held state; after release, the first load occurs on the first edge with Reset=0 and Freeze=0.

Verification
REQ-029 Reset, Auto=0, Sel=2, Regs ch2=16'h1A2F -> Hex digits (3..0) = 1,A,2,F patterns and Chan=2 two cycles after reset release; Blank=0.
REQ-030 Manual Sel=7 with CHANNELS=5 -> Blank=1, Hex=all ones, Chan=7 after 2 cycles; Sel back to 0 -> normal display after 2 cycles.
REQ-031 DWELL=4, Auto=1 from ch=3 -> Chan sequence 3,4,0,1, each held exactly 4 cycles; wrap from 4 to 0 verified.
REQ-032 Auto=1, Freeze=1 for 10 cycles mid-dwell while Regs change -> Hex/Chan unchanged; after release, the remaining dwell completes the original 4-cycle count.
REQ-033 Reset pulse during Freeze=1 with Chan=3 -> Chan=0, Blank=1 the next cycle; remains blank until Freeze drops.
REQ-034 Regs ch0=16'h8888, Sel=0 -> every digit = 7'b0000000; Regs ch0=16'h0000 -> every digit = 7'b1000000.
